// File: rtl/onehot_decoder_fifo_if.sv
// Valid/ready bus bundle for the one-hot decoder FIFO: code intake and one-hot delivery.
interface onehot_decoder_fifo_if #(
    parameter int IN_W = 2
);
    localparam int OUT_W = 2 ** IN_W;

    logic             in_valid;
    logic [IN_W-1:0]  in_code;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_onehot;
    logic             out_ready;

    // Producer/consumer side: supplies codes and accepts one-hot words.
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_onehot
    );
endinterface

// File: rtl/onehot_decoder_fifo.sv
// Registered binary-to-one-hot decoder: buffers binary codes in a small FIFO,
// decodes the head entry on the read side and counts hits per output line.
module onehot_decoder_fifo #(
    parameter int IN_W  = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clr_cnt,
    onehot_decoder_fifo_if.slave            io,
    output logic [$clog2(DEPTH):0]          level,
    output logic [(2**IN_W)*CNT_W-1:0]      hit_cnt
);
    localparam int OUT_W = 2 ** IN_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [IN_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt [OUT_W];
    logic [IN_W-1:0]  head;
    logic             push;
    logic             pop;

    // Handshake decode; in_ready depends only on registered level, never on out_ready.
    always_comb begin
        io.in_ready  = !rst && en && (level < FULL);
        io.out_valid = (level != '0);
        head         = mem[rd_ptr];
        push         = io.in_valid && io.in_ready;
        pop          = io.out_valid && io.out_ready;
    end

    // Read-side decode of the head code; zero while the FIFO is empty.
    always_comb begin
        io.out_onehot = '0;
        if (io.out_valid) begin
            io.out_onehot = OUT_W'(1) << head;
        end
    end

    // Code storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io.in_code;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Saturating per-line hit counters; clear takes priority over a pop.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                cnt[i] <= '0;
            end
        end else if (pop && (cnt[head] != '1)) begin
            cnt[head] <= cnt[head] + 1'b1;
        end
    end

    // Pack counters: line i occupies bits [i*CNT_W +: CNT_W].
    always_comb begin
        hit_cnt = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// Directed, table-driven bench for onehot_decoder_fifo (IN_W=2, DEPTH=2, CNT_W=2).
module tb_onehot_decoder_fifo;
    localparam int IN_W  = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int OUT_W = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_cnt;
    logic [1:0] level;
    logic [7:0] hit_cnt;

    int nchecks;
    int nerrors;

    onehot_decoder_fifo_if #(.IN_W(IN_W)) io ();

    onehot_decoder_fifo #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_cnt (clr_cnt),
        .io      (io),
        .level   (level),
        .hit_cnt (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       iv;
        logic [1:0] code;
        logic       ordy;
        logic       clr;
        logic       exp_irdy;
        logic       exp_ov;
        logic [3:0] exp_oh;
        logic [1:0] exp_lvl;
        logic [7:0] exp_hit;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic e, logic iv, logic [1:0] c, logic ordy, logic clr,
                                logic irdy, logic ov, logic [3:0] oh, logic [1:0] lvl,
                                logic [7:0] hit);
        vec_t v;
        v.en = e; v.iv = iv; v.code = c; v.ordy = ordy; v.clr = clr;
        v.exp_irdy = irdy; v.exp_ov = ov; v.exp_oh = oh; v.exp_lvl = lvl; v.exp_hit = hit;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic e, logic iv, logic [1:0] c, logic ordy, logic clr);
        en = e; io.in_valid = iv; io.in_code = c; io.out_ready = ordy; clr_cnt = clr;
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        // Hit patterns are {line3, line2, line1, line0}, 2 bits each.
        // Reset state and single code, plus clear winning over a pop.
        tbl.push_back(mk(1,1,2'd2,0,0, 1,0,4'b0000,2'd0, {2'd0,2'd0,2'd0,2'd0}));
        tbl.push_back(mk(1,0,2'd0,0,0, 1,1,4'b0100,2'd1, {2'd0,2'd0,2'd0,2'd0}));
        tbl.push_back(mk(0,0,2'd0,1,1, 0,1,4'b0100,2'd1, {2'd0,2'd0,2'd0,2'd0}));
        // Streaming 00,01,10,11 with out_ready held high.
        tbl.push_back(mk(1,1,2'd0,1,0, 1,0,4'b0000,2'd0, {2'd0,2'd0,2'd0,2'd0}));
        tbl.push_back(mk(1,1,2'd1,1,0, 1,1,4'b0001,2'd1, {2'd0,2'd0,2'd0,2'd0}));
        tbl.push_back(mk(1,1,2'd2,1,0, 1,1,4'b0010,2'd1, {2'd0,2'd0,2'd0,2'd1}));
        tbl.push_back(mk(1,1,2'd3,1,0, 1,1,4'b0100,2'd1, {2'd0,2'd0,2'd1,2'd1}));
        tbl.push_back(mk(1,0,2'd0,1,0, 1,1,4'b1000,2'd1, {2'd0,2'd1,2'd1,2'd1}));
        // Fill, backpressure, full-with-pop blocks push.
        tbl.push_back(mk(1,1,2'd3,0,0, 1,0,4'b0000,2'd0, {2'd1,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,1,2'd1,0,0, 1,1,4'b1000,2'd1, {2'd1,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,1,2'd2,0,0, 0,1,4'b1000,2'd2, {2'd1,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,1,2'd2,0,0, 0,1,4'b1000,2'd2, {2'd1,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,1,2'd2,1,0, 0,1,4'b1000,2'd2, {2'd1,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,1,2'd2,0,0, 1,1,4'b0010,2'd1, {2'd2,2'd1,2'd1,2'd1}));
        // Drain, then simultaneous push and pop at level 1.
        tbl.push_back(mk(1,0,2'd0,1,0, 0,1,4'b0010,2'd2, {2'd2,2'd1,2'd1,2'd1}));
        tbl.push_back(mk(1,0,2'd0,1,0, 1,1,4'b0100,2'd1, {2'd2,2'd1,2'd2,2'd1}));
        tbl.push_back(mk(1,1,2'd0,0,0, 1,0,4'b0000,2'd0, {2'd2,2'd2,2'd2,2'd1}));
        tbl.push_back(mk(1,1,2'd2,1,0, 1,1,4'b0001,2'd1, {2'd2,2'd2,2'd2,2'd1}));
        tbl.push_back(mk(1,0,2'd0,0,0, 1,1,4'b0100,2'd1, {2'd2,2'd2,2'd2,2'd2}));
        tbl.push_back(mk(1,0,2'd0,1,0, 1,1,4'b0100,2'd1, {2'd2,2'd2,2'd2,2'd2}));
        // out_ready while empty has no effect; line2 saturated at 3.
        tbl.push_back(mk(1,0,2'd0,1,0, 1,0,4'b0000,2'd0, {2'd2,2'd3,2'd2,2'd2}));
        tbl.push_back(mk(1,0,2'd0,0,0, 1,0,4'b0000,2'd0, {2'd2,2'd3,2'd2,2'd2}));

        // Reset cycle: in_ready must be low.
        #1;
        chk("rst_in_ready", {31'd0, io.in_ready}, 32'd0);
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].iv, tbl[i].code, tbl[i].ordy, tbl[i].clr);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, io.in_ready}, {31'd0, tbl[i].exp_irdy});
            chk($sformatf("v%0d_out_valid", i), {31'd0, io.out_valid}, {31'd0, tbl[i].exp_ov});
            chk($sformatf("v%0d_out_onehot", i), {28'd0, io.out_onehot}, {28'd0, tbl[i].exp_oh});
            chk($sformatf("v%0d_level", i), {30'd0, level}, {30'd0, tbl[i].exp_lvl});
            chk($sformatf("v%0d_hit_cnt", i), {24'd0, hit_cnt}, {24'd0, tbl[i].exp_hit});
            tick();
        end

        // en=0 blocks intake while buffered entries drain.
        drive(1, 1, 2'd1, 0, 0); #1; tick();
        drive(1, 1, 2'd3, 0, 0); #1; tick();
        drive(0, 1, 2'd0, 0, 0); #1;
        chk("en0_in_ready", {31'd0, io.in_ready}, 32'd0);
        chk("en0_level", {30'd0, level}, 32'd2);
        tick();
        drive(0, 1, 2'd0, 1, 0); #1;
        chk("en0_drain0", {28'd0, io.out_onehot}, 32'b0010);
        tick();
        #1;
        chk("en0_drain1", {28'd0, io.out_onehot}, 32'b1000);
        chk("en0_in_ready_hold", {31'd0, io.in_ready}, 32'd0);
        tick();
        #1;
        chk("en0_empty_level", {30'd0, level}, 32'd0);
        chk("en0_empty_valid", {31'd0, io.out_valid}, 32'd0);

        // Refill, then reset mid-operation with a code offered.
        drive(1, 1, 2'd0, 0, 0); #1; tick();
        drive(1, 1, 2'd2, 0, 0); #1; tick();
        #1;
        chk("refill_level", {30'd0, level}, 32'd2);
        rst = 1'b1;
        drive(1, 1, 2'd1, 1, 0); #1;
        chk("midrst_in_ready", {31'd0, io.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1, 0, 2'd0, 0, 0); #1;
        chk("midrst_level", {30'd0, level}, 32'd0);
        chk("midrst_valid", {31'd0, io.out_valid}, 32'd0);
        chk("midrst_onehot", {28'd0, io.out_onehot}, 32'd0);
        chk("midrst_hit", {24'd0, hit_cnt}, 32'd0);

        // Saturation of line1 over five pops of code 01.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 2'd1, 0, 0); #1; tick();
            drive(1, 0, 2'd0, 1, 0); #1; tick();
            #1;
            chk($sformatf("sat_line1_%0d", k), {30'd0, hit_cnt[2 +: 2]}, (k < 3) ? k + 1 : 3);
        end

        // Clear together with a pop of 01: clear wins.
        drive(1, 1, 2'd1, 0, 0); #1; tick();
        drive(1, 0, 2'd0, 1, 1); #1;
        chk("clr_pre_onehot", {28'd0, io.out_onehot}, 32'b0010);
        tick();
        drive(1, 0, 2'd0, 0, 0); #1;
        chk("clr_line1", {30'd0, hit_cnt[2 +: 2]}, 32'd0);
        chk("clr_all", {24'd0, hit_cnt}, 32'd0);
        chk("clr_level", {30'd0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_fifo.md
Name: onehot_decoder_fifo

Overview:
- Registered N-to-2^N binary-to-one-hot decoder. Receives a stream of binary codes over a valid/ready handshake, buffers them in a small FIFO, and presents one-hot words on a downstream valid/ready handshake.
- Keeps a saturating hit counter per output line for debug and coverage.
- Sits on the receive side of the priority/one-hot encoders in the combinational-circuits library and restores their one-hot form.

Parameters:
IN_W, 2, input code width; the one-hot output width is OUT_W = 2**IN_W (4 by default)
DEPTH, 2, FIFO depth in entries; power of two, minimum 2
CNT_W, 8, width of each per-line hit counter

Ports:
clk  input  1  rising-edge clock for all state
rst  input  1  synchronous, active-high reset
en  input  1  intake enable; 0 blocks new codes, and buffered entries still drain
in_valid  input  1  upstream code valid
in_code  input  IN_W  binary code
in_ready  output  1  decoder accepts a code this cycle
out_valid  output  1  one-hot word available
out_onehot  output  OUT_W  decoded one-hot word; all zeros when out_valid=0
out_ready  input  1  downstream accepts the word
level  output  clog2(DEPTH)+1  FIFO occupancy
clr_cnt  input  1  synchronous clear of all hit counters
hit_cnt  output  OUT_W*CNT_W  packed counters; line i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=1 at a clk edge):
  - level=0, out_valid=0, out_onehot=0, all hit counters=0.
  - in_ready is low during the reset cycle.
  - Pointers reset to 0. Reset mid-transfer discards all buffered entries, and no handshake completes in the reset cycle.
- Push: occurs when in_valid && in_ready.
  - in_ready = en && (level < DEPTH), computed from registered level only.
  - There is no combinational path from out_ready to in_ready. When full, a simultaneous pop does not allow a push in that cycle.
  - in_valid && !in_ready means the code is held upstream. The decoder records nothing and flags no error.
- Storage: the FIFO stores the binary code, not the one-hot word. Decoding is applied on the read side.
- Output:
  - out_valid = (level != 0).
  - out_onehot = 1 << code at the head when out_valid=1, else 0.
  - Latency: a code pushed at edge k is visible on out_valid/out_onehot after edge k, i.e. 1 cycle when the FIFO was empty. There is no bypass within the same cycle.
- Pop: occurs when out_valid && out_ready. The head advances at the edge. out_ready while empty has no effect.
- Level:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, and both pointers advance.
  - Neither event: unchanged.
- Pointers wrap modulo DEPTH.
- Order: strictly FIFO. Every accepted code is delivered exactly once.
- Output holding: while out_valid=1 and out_ready=0, out_onehot is held stable.
- en behaviour: en=0 only gates in_ready. Buffered words continue to drain, and counters continue to update.
- Hit counters:
  - On each pop, counter[head code] increments by 1.
  - A counter saturates at 2**CNT_W-1 and never wraps.
  - If clr_cnt=1, all counters are 0 after the edge. Clear wins over a simultaneous pop.
- Invariants: out_onehot has exactly one bit set when out_valid=1. No X or Z is ever driven on any output after reset.

Test Plan:
1. Reset, then a single code:
   - After reset, level=0, out_valid=0, out_onehot=0000, in_ready=1 with en=1.
   - Push code 2'b10 with out_ready=0 -> on the next cycle out_valid=1, out_onehot=0100, level=1.
2. Full sequence:
   - Push 00, 01, 10, 11 with out_ready=1 continuously -> outputs 0001, 0010, 0100, 1000 in order, each 1 cycle after its push.
   - Afterwards hit_cnt = {1,1,1,1}.
3. Fill and backpressure:
   - Hold out_ready=0 and push 11, then 01 -> level=2, in_ready=0.
   - A third code held on in_valid is not accepted.
   - Assert out_ready for 1 cycle -> 1000 pops. in_ready stays 0 in that cycle and returns to 1 the following cycle.
   - Next word presented: 0010.
4. Simultaneous push and pop:
   - With level=1 (head 00), push 10 and pop in the same cycle -> level stays 1.
   - Next out_onehot=0100.
5. Enable and reset mid-operation:
   - With 2 entries buffered, drive en=0 -> in_ready=0, and both entries still drain.
   - Refill with 2 entries, assert rst for 1 cycle -> level=0, out_valid=0, and the counters are cleared.
6. Counter saturation and clear (CNT_W=2):
   - Pop code 01 five times -> hit_cnt line1 = 3 (saturated).
   - Assert clr_cnt together with a pop of 01 -> line1 = 0 afterwards.
